// File: rtl/serial_deser_pkg.sv
// Shared types and default constants for the serial frame deserializer.
// Frame counter width and FSM encoding live here so the top and bench agree.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  localparam int             SYNC_W_DEF   = 4;
  localparam logic [3:0]     SYNC_PAT_DEF = 4'b1011;
  localparam int             DATA_W_DEF   = 8;
  localparam int             FRAME_CNT_W  = 8;

endpackage

// File: rtl/serial_frame_deser_sync_window.sv
// Sync-pattern hunter: SYNC_W-bit serial window with a comparator on the
// window as it will look after the current bit is shifted in.
module sync_window
  import serial_deser_pkg::*;
#(
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_en,
  input  logic clear,
  output logic match
);

  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] window_next;

  assign window_next = {window[SYNC_W-2:0], bit_in};
  assign match       = bit_en && (window_next == SYNC_PAT);

  // Clearing on a hit forces every later frame to present a complete pattern.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      window <= '0;
    end else if (bit_en) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: sync hunt, word shift-in and one-entry valid/ready
// output buffer. Define SERIAL_DESER_PARITY_EN to add a trailing even-parity bit.
module serial_frame_deser
  import serial_deser_pkg::*;
#(
  parameter int                SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_PAT_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_in,
  input  logic                   bit_en,
  output logic [DATA_W-1:0]      word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   locked,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  deser_state_t      state;
  deser_state_t      state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] done_word;
  logic              last_bit;
  logic              win_en;
  logic              win_match;
  logic              word_done;
  logic              can_load;

`ifdef SERIAL_DESER_PARITY_EN
  logic parity_fail;
`endif

  assign win_en   = bit_en && (state == HUNT);
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign can_load = !word_valid || word_ready;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_next = {shreg[DATA_W-2:0], bit_in};
    end else begin : g_lsb_first
      assign shreg_next = {bit_in, shreg[DATA_W-1:1]};
    end
  endgenerate

`ifdef SERIAL_DESER_PARITY_EN
  assign done_word = shreg;
`else
  assign done_word = shreg_next;
`endif

  sync_window #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync_window (
    .clk    (clk),
    .reset  (reset),
    .bit_in (bit_in),
    .bit_en (win_en),
    .clear  (win_match),
    .match  (win_match)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    locked     = (state == SHIFT);
`ifdef SERIAL_DESER_PARITY_EN
    parity_fail = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (win_match) state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_en && last_bit) begin
`ifdef SERIAL_DESER_PARITY_EN
          state_next = PARITY;
`else
          state_next = HUNT;
          word_done  = 1'b1;
`endif
        end
      end
      PARITY: begin
`ifdef SERIAL_DESER_PARITY_EN
        // Even parity: data bits plus the parity bit must XOR to zero.
        if (bit_en) begin
          state_next = HUNT;
          if (^{shreg, bit_in}) parity_fail = 1'b1;
          else                  word_done   = 1'b1;
        end
`else
        state_next = HUNT;
`endif
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_en) begin
      if (state == SHIFT) begin
        shreg   <= shreg_next;
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end else if (win_match) begin
        bit_cnt <= '0;
      end
    end
  end

  // A finished word is loaded if the buffer is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (can_load) begin
        word_out   <= done_word;
        word_valid <= 1'b1;
        frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
      end else begin
        overrun    <= 1'b1;
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (parity_fail) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser with a queue-based reference model.
// Honours SERIAL_DESER_PARITY_EN when compiled with the same define as the RTL.
module tb_serial_frame_deser;
  import serial_deser_pkg::*;

  localparam int             DW  = DATA_W_DEF;
  localparam int             SW  = SYNC_W_DEF;
  localparam logic [SW-1:0]  PAT = SYNC_PAT_DEF;
  localparam bit             TB_MSB_FIRST = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_en = 1'b0;
  logic          word_ready = 1'b0;
  logic [DW-1:0] word_out;
  logic          word_valid;
  logic          locked;
  logic [7:0]    frame_cnt;
  logic          overrun;
  logic          parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level mode, bit queues and buffer contents.
  int            m_mode;
  bit            m_win[$];
  bit            m_data[$];
  logic [DW-1:0] m_pending;
  logic [DW-1:0] m_word;
  logic          m_valid;
  logic [7:0]    m_cnt;
  logic          m_ovr;
  logic          m_perr;

  always #5 clk = ~clk;

  serial_frame_deser #(
    .SYNC_W    (SW),
    .SYNC_PAT  (PAT),
    .DATA_W    (DW),
    .MSB_FIRST (TB_MSB_FIRST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .locked     (locked),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic model_update(input logic en, input logic b, input logic rdy, input logic rst_n);
    bit done;
    int v;
    bit p;
    logic [SW-1:0] pat;
    pat = PAT;
    if (!rst_n) begin
      m_mode = 0;
      m_win.delete();
      for (int i = 0; i < SW; i++) m_win.push_back(1'b0);
      m_data.delete();
      m_pending = '0;
      m_word = '0;
      m_valid = 1'b0;
      m_cnt = '0;
      m_ovr = 1'b0;
      m_perr = 1'b0;
      return;
    end
    done = 1'b0;
    if (en) begin
      if (m_mode == 0) begin
        m_win.push_back(b);
        void'(m_win.pop_front());
        v = 0;
        for (int i = 0; i < SW; i++) v = v * 2 + int'(m_win[i]);
        if (v == int'(pat)) begin
          m_mode = 1;
          m_data.delete();
          for (int i = 0; i < SW; i++) m_win[i] = 1'b0;
        end
      end else if (m_mode == 1) begin
        m_data.push_back(b);
        if (m_data.size() == DW) begin
          for (int i = 0; i < DW; i++) begin
            if (TB_MSB_FIRST) m_pending[DW-1-i] = m_data[i];
            else              m_pending[i]      = m_data[i];
          end
`ifdef SERIAL_DESER_PARITY_EN
          m_mode = 2;
`else
          m_mode = 0;
          done = 1'b1;
`endif
        end
      end else begin
        p = b;
        foreach (m_data[i]) p = p ^ m_data[i];
        if (p == 1'b0) done = 1'b1;
        else           m_perr = 1'b1;
        m_mode = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word = m_pending;
        m_valid = 1'b1;
        m_cnt = m_cnt + 8'd1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic en, input logic b, input logic rdy);
    bit_en = en;
    bit_in = b;
    word_ready = rdy;
    @(posedge clk);
    model_update(en, b, rdy, reset);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Sends sync, data word and (with the feature) parity XOR flip; rdy_last on final bit.
  task automatic send_frame(input logic [DW-1:0] word, input logic flip, input logic rdy,
                            input logic rdy_last, output int lock_cycles);
    logic [SW-1:0] pat;
    logic b;
    logic r;
    pat = PAT;
    lock_cycles = 0;
    for (int i = SW - 1; i >= 0; i--) begin
      step(1'b1, pat[i], rdy);
      lock_cycles += int'(locked);
    end
    for (int i = 0; i < DW; i++) begin
      b = TB_MSB_FIRST ? word[DW-1-i] : word[i];
`ifdef SERIAL_DESER_PARITY_EN
      r = rdy;
`else
      r = (i == DW - 1) ? rdy_last : rdy;
`endif
      step(1'b1, b, r);
      lock_cycles += int'(locked);
    end
`ifdef SERIAL_DESER_PARITY_EN
    step(1'b1, (^word) ^ flip, rdy_last);
    lock_cycles += int'(locked);
`endif
  endtask

  task automatic test_reset();
    int lc;
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, lc);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(1)), 1'b0);
    checks++;
    if ({word_out, word_valid, locked, frame_cnt, overrun, parity_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got out=%h v=%b l=%b cnt=%0d ovr=%b perr=%b required all zero",
               word_out, word_valid, locked, frame_cnt, overrun, parity_err);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (word_valid !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_sync: got valid=%b locked=%b required 0/0", word_valid, locked);
      end
    end
  endtask

  task automatic test_basic_frame();
    int lc;
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, lc);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'hA5 || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL basic_word: got valid=%b out=%h cnt=%0d required 1/a5/1", word_valid, word_out, frame_cnt);
    end
    checks++;
    if (lc !== 8) begin
      errors++;
      $display("[TB] FAIL basic_locked_cycles: got %0d required 8", lc);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (word_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_drain: got valid=%b locked=%b required 0/0", word_valid, locked);
    end
  endtask

  task automatic test_false_sync_gaps();
    logic [5:0] seq;
    logic [DW-1:0] word;
    logic b;
    seq = 6'b101011;
    word = 8'h5A;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[5-i], 1'b1);
      checks++;
      if (locked !== (i == 5)) begin
        errors++;
        $display("[TB] FAIL false_sync_bit%0d: got locked=%b required %b", i, locked, (i == 5));
      end
      step(1'b0, 1'($urandom_range(1)), 1'b1);
    end
    for (int i = 0; i < DW; i++) begin
      b = TB_MSB_FIRST ? word[DW-1-i] : word[i];
      step(1'b1, b, 1'b1);
      if (i != DW - 1) step(1'b0, ~b, 1'b1);
    end
`ifdef SERIAL_DESER_PARITY_EN
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, ^word, 1'b1);
`endif
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h5A || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL gap_word: got valid=%b out=%h cnt=%0d required 1/5a/1", word_valid, word_out, frame_cnt);
    end
  endtask

  task automatic test_overrun();
    int lc;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, lc);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, lc);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h3C || overrun !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL overrun_state: got valid=%b out=%h ovr=%b cnt=%0d required 1/3c/1/1",
               word_valid, word_out, overrun, frame_cnt);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (word_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_drain: got valid=%b ovr=%b required 0/1", word_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, lc);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, lc);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h22 || overrun !== 1'b0 || frame_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL drain_load: got valid=%b out=%h ovr=%b cnt=%0d required 1/22/0/2",
               word_valid, word_out, overrun, frame_cnt);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h22) begin
      errors++;
      $display("[TB] FAIL hold_stable: got valid=%b out=%h required 1/22", word_valid, word_out);
    end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    int lc;
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, lc);
    checks++;
    if (word_valid !== 1'b1 || parity_err !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL parity_good: got valid=%b perr=%b cnt=%0d required 1/0/1", word_valid, parity_err, frame_cnt);
    end
    step(1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, lc);
    checks++;
    if (word_valid !== 1'b0 || parity_err !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL parity_bad: got valid=%b perr=%b cnt=%0d required 0/1/1", word_valid, parity_err, frame_cnt);
    end
  endtask
`endif

  task automatic test_wrap();
    int lc;
    do_reset();
    for (int i = 0; i < 255; i++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b1, lc);
    checks++;
    if (frame_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL wrap_255: got %0d required 255", frame_cnt);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, lc);
    checks++;
    if (frame_cnt !== 8'd0 || word_out !== 8'h81) begin
      errors++;
      $display("[TB] FAIL wrap_0: got cnt=%0d out=%h required 0/81", frame_cnt, word_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
      step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(2) == 0));
      reset = 1'b1;
      checks++;
      if (word_valid !== m_valid || word_out !== m_word) begin
        errors++;
        $display("[TB] FAIL rand_buffer@%0d: got valid=%b out=%h required %b/%h", cyc, word_valid, word_out, m_valid, m_word);
      end
      checks++;
      if (frame_cnt !== m_cnt || overrun !== m_ovr || parity_err !== m_perr) begin
        errors++;
        $display("[TB] FAIL rand_status@%0d: got cnt=%0d ovr=%b perr=%b required %0d/%b/%b",
                 cyc, frame_cnt, overrun, parity_err, m_cnt, m_ovr, m_perr);
      end
      checks++;
      if (locked !== (m_mode == 1)) begin
        errors++;
        $display("[TB] FAIL rand_locked@%0d: got %b required %b", cyc, locked, (m_mode == 1));
      end
    end
  endtask

  initial begin
    model_update(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic_frame();
    test_false_sync_gaps();
    test_overrun();
    test_back_to_back();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
